// File: rtl/sync_filter_bank_pkg.sv
// Helpers for the synchronizer/debounce bank.
// Counter sizing shared by the bank and its channels.
package sync_filter_bank_pkg;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sys_structs.sv
// Shared system structures: clock-domain bundle used across blocks.
// Carries the clock, its enable and a synchronous reset request.
package sys_structs;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_sain;

endpackage

// File: rtl/sync_filter_bank_if.sv
// Bundle of the raw inputs and the filtered level / edge outputs.
// master drives raw data, slave returns filtered results.
interface sync_filter_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] data;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (output data, input level, input rise, input fall);
    modport slave  (input data, output level, output rise, output fall);
endinterface

// File: rtl/debounce_channel.sv
// One channel: persistence filter on a synchronized level, plus edge pulses.
// Edge registers exist only with SYNC_FILTER_BANK_EDGE_EN defined.
module debounce_channel
    import sync_filter_bank_pkg::*;
#(
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          diff;
    logic          fire;

    assign diff = raw ^ level;
    assign fire = en & diff & (cnt == CNT_MAX);

    // Count enabled cycles of disagreement; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= RESET_LEVEL;
        end else if (en) begin
            if (!diff) begin
                cnt <= '0;
            end else if (fire) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SYNC_FILTER_BANK_EDGE_EN
    // Pulse for exactly one edge when the level flips; clears regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= fire & raw;
            fall <= fire & ~raw;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of CDC synchronizers each followed by a debounce filter.
// Optional edge pulses: define SYNC_FILTER_BANK_EDGE_EN.
module sync_filter_bank #(
    parameter int                  CHANNELS      = 4,
    parameter int                  SYNC_DEPTH    = 3,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  sys_structs::clk_dom_sain clk_dom_s_i,
    input  logic                     async_rst_n,
    input  logic [CHANNELS-1:0]      data_i,
    output logic [CHANNELS-1:0]      data_o,
    output logic [CHANNELS-1:0]      rise_o,
    output logic [CHANNELS-1:0]      fall_o
);
    logic                clk;
    logic                clk_en;
    logic                unused_sync_rst;
    logic [CHANNELS-1:0] sync_q [SYNC_DEPTH];

    assign clk             = clk_dom_s_i.clk;
    assign clk_en          = clk_dom_s_i.clk_en;
    assign unused_sync_rst = clk_dom_s_i.sync_rst;

    // Plain flop chain every edge; no logic between stages.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int s = 0; s < SYNC_DEPTH; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int s = 1; s < SYNC_DEPTH; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        debounce_channel #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_LEVEL   (RESET_VALUE[c])
        ) u_ch (
            .clk   (clk),
            .rst_n (async_rst_n),
            .en    (clk_en),
            .raw   (sync_q[SYNC_DEPTH-1][c]),
            .level (data_o[c]),
            .rise  (rise_o[c]),
            .fall  (fall_o[c])
        );
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank (CHANNELS=4, SYNC_DEPTH=2, FILTER_CYCLES=3).
// Edge expectations follow SYNC_FILTER_BANK_EDGE_EN.
module tb_sync_filter_bank;

`ifdef SYNC_FILTER_BANK_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    sys_structs::clk_dom_sain clk_dom;
    logic async_rst_n;
    int   vectors;
    int   miscompares;

    sync_filter_bank_if #(.CHANNELS(4)) bus ();

    sync_filter_bank #(
        .CHANNELS      (4),
        .SYNC_DEPTH    (2),
        .FILTER_CYCLES (3),
        .RESET_VALUE   (4'b0000)
    ) dut (
        .clk_dom_s_i (clk_dom),
        .async_rst_n (async_rst_n),
        .data_i      (bus.data),
        .data_o      (bus.level),
        .rise_o      (bus.rise),
        .fall_o      (bus.fall)
    );

    initial begin
        clk_dom.clk = 1'b0;
        forever #5 clk_dom.clk = ~clk_dom.clk;
    end

    task automatic tick;
        @(posedge clk_dom.clk);
        #1;
    endtask

    task automatic test_reset;
        async_rst_n      = 1'b0;
        clk_dom.clk_en   = 1'b1;
        clk_dom.sync_rst = 1'b0;
        bus.data         = 4'b0000;
        #1;
        vectors++;
        if ({bus.level, bus.rise, bus.fall} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state got %b/%b/%b want 0000/0000/0000",
                     bus.level, bus.rise, bus.fall);
        end
        repeat (3) tick();
        @(negedge clk_dom.clk);
        async_rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({bus.level, bus.rise, bus.fall} !== 12'h000) begin
                miscompares++;
                $display("FAIL idle_after_reset k=%0d got %b/%b/%b want 0",
                         k, bus.level, bus.rise, bus.fall);
            end
        end
    endtask

    task automatic test_async_reset;
        bus.data = 4'b0101;
        repeat (5) tick();
        vectors++;
        if (bus.level !== 4'b0101) begin
            miscompares++;
            $display("FAIL preload_level got %b want 0101", bus.level);
        end
        #2;
        async_rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.level, bus.rise, bus.fall} !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset got %b/%b/%b want 0",
                     bus.level, bus.rise, bus.fall);
        end
        bus.data = 4'b0000;
        @(negedge clk_dom.clk);
        async_rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({bus.level, bus.rise, bus.fall} !== 12'h000) begin
                miscompares++;
                $display("FAIL post_async_reset k=%0d got %b/%b/%b want 0",
                         k, bus.level, bus.rise, bus.fall);
            end
        end
    endtask

    task automatic test_step;
        logic el;
        logic er;
        tick();
        bus.data[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            el = (k >= 5);
            er = EDGE && (k == 5);
            vectors++;
            if (bus.level[0] !== el || bus.rise[0] !== er || bus.fall[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL step k=%0d got lvl=%b rise=%b fall=%b want %b/%b/0",
                         k, bus.level[0], bus.rise[0], bus.fall[0], el, er);
            end
        end
    endtask

    task automatic test_glitch;
        bus.data[1] = 1'b1;
        tick();
        tick();
        bus.data[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (bus.level[1] !== 1'b0 || bus.rise[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch k=%0d got lvl=%b rise=%b want 0/0",
                         k, bus.level[1], bus.rise[1]);
            end
        end
    endtask

    task automatic test_clk_en;
        logic el;
        logic er;
        bus.data[2] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) clk_dom.clk_en = 1'b0;
            if (k == 7) clk_dom.clk_en = 1'b1;
            el = (k >= 9);
            er = EDGE && (k == 9);
            vectors++;
            if (bus.level[2] !== el || bus.rise[2] !== er) begin
                miscompares++;
                $display("FAIL clk_en k=%0d got lvl=%b rise=%b want %b/%b",
                         k, bus.level[2], bus.rise[2], el, er);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] el;
        logic [3:0] er;
        logic [3:0] ef;
        bus.data = 4'b0000;
        repeat (8) tick();
        vectors++;
        if (bus.level !== 4'b0000) begin
            miscompares++;
            $display("FAIL settle got %b want 0000", bus.level);
        end
        bus.data = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) bus.data = 4'b0000;
            el = ((k >= 5 && k < 15) ? 4'b1111 : 4'b0000);
            er = (EDGE && k == 5)  ? 4'b1111 : 4'b0000;
            ef = (EDGE && k == 15) ? 4'b1111 : 4'b0000;
            vectors++;
            if (bus.level !== el || bus.rise !== er || bus.fall !== ef
                || (bus.rise & bus.fall) !== 4'b0000) begin
                miscompares++;
                $display("FAIL simultaneous k=%0d got %b/%b/%b want %b/%b/%b",
                         k, bus.level, bus.rise, bus.fall, el, er, ef);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_async_reset();
        test_step();
        test_glitch();
        test_clk_en();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
